// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle 4-bit-opcode CPU control path:
// opcode values, ALU control encodings, datapath mux selects and the
// sequencer state enumeration. There are no ports; the package is imported
// by multicycle_control and multicycle_outdec.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Instruction opcodes (4-bit field of the instruction register)
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_J    = 4'b0111;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_INC  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Sequencer states; encodings 13..15 are unreachable
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    EXECI  = 4'd4,
    ALUWB  = 4'd5,
    MEMADR = 4'd6,
    MEMRD  = 4'd7,
    MEMWB  = 4'd8,
    MEMWR  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  // ALU operation used in EXEC for a given R-type opcode
  function automatic logic [2:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_for_op = ALU_SUB;
      OP_AND:  alu_for_op = ALU_AND;
      default: alu_for_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// -----------------------------------------------------------------------------
// multicycle_outdec
// Combinational decoder from the sequencer state to the datapath control word.
// Outputs are a pure function of the state, except the FETCH write strobes,
// which complete in the cycle the memory reports ready.
//
// Ports:
//   state_i        current sequencer state (4-bit encoding of state_t)
//   exec_alu_i     ALU operation latched at DECODE, used in EXEC
//   mem_ready_i    memory completes the current access this cycle
//   mem_req_o .. illegal_o   datapath control signals (see multicycle_control)
// -----------------------------------------------------------------------------
module multicycle_outdec
  import cpu_pkg::*;
#(
  parameter int ACW = 3
) (
  input  logic [3:0]     state_i,
  input  logic [ACW-1:0] exec_alu_i,
  input  logic           mem_ready_i,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic           iord_o,
  output logic           irwrite_o,
  output logic           pcwrite_o,
  output logic           pcwrite_cond_o,
  output logic [1:0]     pcsrc_o,
  output logic           alusrca_o,
  output logic [1:0]     alusrcb_o,
  output logic [ACW-1:0] alu_ctrl_o,
  output logic           regwrite_o,
  output logic           memtoreg_o,
  output logic           illegal_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    iord_o         = 1'b0;
    irwrite_o      = 1'b0;
    pcwrite_o      = 1'b0;
    pcwrite_cond_o = 1'b0;
    pcsrc_o        = PCSRC_ALU;
    alusrca_o      = 1'b0;
    alusrcb_o      = SRCB_REGB;
    alu_ctrl_o     = ALU_AND;
    regwrite_o     = 1'b0;
    memtoreg_o     = 1'b0;
    illegal_o      = 1'b0;

    case (state_t'(state_i))
      FETCH: begin
        // PC+1 computed in parallel; IR and PC load when the read completes
        mem_req_o  = 1'b1;
        alusrcb_o  = SRCB_INC;
        alu_ctrl_o = ALU_ADD;
        pcsrc_o    = PCSRC_ALU;
        irwrite_o  = mem_ready_i;
        pcwrite_o  = mem_ready_i;
      end
      DECODE: begin
        // Branch target precompute: PC + sign-extended immediate
        alusrcb_o  = SRCB_IMM;
        alu_ctrl_o = ALU_ADD;
      end
      EXEC: begin
        alusrca_o  = 1'b1;
        alusrcb_o  = SRCB_REGB;
        alu_ctrl_o = exec_alu_i;
      end
      EXECI, MEMADR: begin
        alusrca_o  = 1'b1;
        alusrcb_o  = SRCB_IMM;
        alu_ctrl_o = ALU_ADD;
      end
      ALUWB: begin
        regwrite_o = 1'b1;
      end
      MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
      end
      MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      BRANCH: begin
        alusrca_o      = 1'b1;
        alusrcb_o      = SRCB_REGB;
        alu_ctrl_o     = ALU_SUB;
        pcwrite_cond_o = 1'b1;
        pcsrc_o        = PCSRC_ALUOUT;
      end
      JUMP: begin
        pcwrite_o = 1'b1;
        pcsrc_o   = PCSRC_JUMP;
      end
      TRAP: begin
        illegal_o = 1'b1;
      end
      default: ;  // IDLE and unreachable encodings drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore sequencer for the shared-memory multi-cycle CPU datapath. Steps each
// instruction through FETCH/DECODE and the execute/memory/write-back states,
// waiting on mem_ready during memory accesses. Illegal opcodes lock into TRAP
// until reset.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   run            leave IDLE (sampled in IDLE only)
//   opcode         instruction opcode (sampled in DECODE only)
//   zero           ALU zero flag (branch qualification is done externally)
//   mem_ready      memory completes the current access this cycle
//   mem_req/mem_we/iord            memory request, write, address select
//   irwrite/pcwrite/pcwrite_cond   IR load, PC load, bne-qualified PC load
//   pcsrc/alusrca/alusrcb/ALUControl   datapath mux selects, ALU operation
//   regwrite/memtoreg              register file write, write-back source
//   illegal        sticky illegal-opcode flag
//   state          current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int ACW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           pcwrite_cond,
  output logic [1:0]     pcsrc,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [ACW-1:0] ALUControl,
  output logic           regwrite,
  output logic           memtoreg,
  output logic           illegal,
  output logic [3:0]     state
);

  state_t         state_q, state_d;
  logic [ACW-1:0] exec_alu_q, exec_alu_d;  // ALU op for EXEC, captured in DECODE
  logic           is_sw_q, is_sw_d;        // MEMADR successor, captured in DECODE

  // The zero flag qualifies pcwrite_cond outside this block.
  logic unused_zero;
  assign unused_zero = zero;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      exec_alu_q <= '0;
      is_sw_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exec_alu_q <= exec_alu_d;
      is_sw_q    <= is_sw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exec_alu_d = exec_alu_q;
    is_sw_d    = is_sw_q;

    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        // Opcode is only looked at here; later states use the captured copy.
        exec_alu_d = alu_for_op(opcode);
        is_sw_d    = (opcode == OP_SW);
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: state_d = EXEC;
          OP_ADDI:                state_d = EXECI;
          OP_LW, OP_SW:           state_d = MEMADR;
          OP_BNE:                 state_d = BRANCH;
          OP_J:                   state_d = JUMP;
          default:                state_d = TRAP;
        endcase
      end
      EXEC, EXECI: state_d = ALUWB;
      ALUWB:       state_d = FETCH;
      MEMADR:      state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:       if (mem_ready) state_d = MEMWB;
      MEMWB:       state_d = FETCH;
      MEMWR:       if (mem_ready) state_d = FETCH;
      BRANCH:      state_d = FETCH;
      JUMP:        state_d = FETCH;
      TRAP:        state_d = TRAP;
      default:     state_d = IDLE;  // unreachable encodings recover
    endcase
  end

  assign state = state_q;

  multicycle_outdec #(.ACW(ACW)) u_outdec (
    .state_i        (state_q),
    .exec_alu_i     (exec_alu_q),
    .mem_ready_i    (mem_ready),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .iord_o         (iord),
    .irwrite_o      (irwrite),
    .pcwrite_o      (pcwrite),
    .pcwrite_cond_o (pcwrite_cond),
    .pcsrc_o        (pcsrc),
    .alusrca_o      (alusrca),
    .alusrcb_o      (alusrcb),
    .alu_ctrl_o     (ALUControl),
    .regwrite_o     (regwrite),
    .memtoreg_o     (memtoreg),
    .illegal_o      (illegal)
  );

endmodule
